ysyx_23060240_xbar: RTL and testbench
=====================================

Name: ysyx_23060240_xbar

Overview: Single-master, three-slave AXI-lite crossbar placed between the IFU/LSU arbiter output and the memory-mapped slaves: SRAM (slave 0), UART (slave 1) and CLINT (slave 2). It decodes each address, routes one transaction at a time to the selected slave, and returns DECERR for unmapped addresses.

Parameters:
S0_BASE  32'h8000_0000  SRAM region base
S0_SIZE  32'h0800_0000  SRAM region size in bytes
S1_BASE  32'ha000_03f8  UART region base
S1_SIZE  32'h0000_0008  UART region size
S2_BASE  32'ha000_0048  CLINT region base
S2_SIZE  32'h0000_0008  CLINT region size

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
m_araddr  in  32  master read address
m_arvalid  in  1  master read address valid
m_arready  out  1  master read address accept
m_rdata  out  32  read data to master
m_rresp  out  2  read response: 00 OKAY, 11 DECERR
m_rvalid  out  1  read data valid
m_rready  in  1  master ready for read data
m_awaddr  in  32  master write address
m_awvalid  in  1  write address valid
m_awready  out  1  write address accept
m_wdata  in  32  write data
m_wvalid  in  1  write data valid
m_wready  out  1  write data accept
m_bresp  out  2  write response: 00 OKAY, 11 DECERR
m_bvalid  out  1  write response valid
m_bready  in  1  master ready for write response
s_araddr  out  32  latched read address, broadcast to all slaves
s_arvalid  out  3  per-slave read address valid, one-hot or zero
s_arready  in  3  per-slave read address ready
s_rdata  in  96  per-slave read data, slave i at bits [32i+31:32i]
s_rvalid  in  3  per-slave read data valid
s_rready  out  3  per-slave read data ready
s_awaddr  out  32  latched write address, broadcast
s_awvalid  out  3  per-slave write address valid
s_awready  in  3  per-slave write address ready
s_wdata  out  32  latched write data, broadcast
s_wvalid  out  3  per-slave write data valid
s_wready  in  3  per-slave write data ready
s_bvalid  in  3  per-slave write response valid
s_bready  out  3  per-slave write response ready

Behaviour:
- Decode: slave i hits when (addr - Si_BASE) < Si_SIZE, computed as 32-bit unsigned, so no overflow at region ends. Lowest index wins on overlap. No hit means the address is unmapped.
- FSM states: IDLE, RD_REQ, RD_RESP, WR_REQ, WR_RESP, ERR_R, ERR_W. At most one transaction is outstanding.
- IDLE, read accept: m_arready=1 when m_arvalid=1. Accepting latches the address and decode result. The next state is RD_REQ on a hit, ERR_R on a miss.
- IDLE, write accept: when m_arvalid=0 and m_awvalid=m_wvalid=1, m_awready=m_wready=1 in the same cycle. Address, data and decode result are latched. The next state is WR_REQ on a hit, ERR_W on a miss.
- Reads have priority over writes when both are pending in IDLE. A lone awvalid or lone wvalid is not accepted.
- RD_REQ: s_arvalid[sel]=1 until s_arready[sel]; then go to RD_RESP.
- RD_RESP: m_rvalid=s_rvalid[sel], m_rdata=slave sel data, m_rresp=00, s_rready[sel]=m_rready. Return to IDLE on the handshake.
- WR_REQ: s_awvalid[sel] and s_wvalid[sel] are raised together. Each drops independently after its own handshake, tracked by two done flags. Go to WR_RESP when both flags are set, including when both handshakes happen in the same cycle.
- WR_RESP: m_bvalid=s_bvalid[sel], m_bresp=00, s_bready[sel]=m_bready. Return to IDLE on the handshake.
- ERR_R: m_rvalid=1, m_rresp=11, m_rdata=0 until m_rready, then IDLE.
- ERR_W: m_bvalid=1, m_bresp=11 until m_bready, then IDLE. No slave sees any valid in either error state.
- Outputs of non-selected slaves are always 0. Master-side ready/valid outputs are 0 outside the states listed above.
- Reset: state goes to IDLE, done flags and latched address/data/sel clear to 0, all s_* valid/ready outputs are 0, and all m_* valid outputs are 0. During rst, m_arready=m_awready=m_wready=0.
- Reset mid-transaction aborts it immediately. Slaves share rst, so no orphan handshake remains.
- Latency, minimum: read takes 3 cycles from m_arvalid to m_rvalid (accept, slave AR, R with a zero-wait slave). A DECERR read takes 2 cycles.

Decomposition: Put the state encoding and the RESP_OKAY/RESP_DECERR constants in a shared ysyx_23060240_axi_pkg. A combinational sub-module ysyx_23060240_addr_dec (addr in, 3-bit one-hot hit plus a miss flag out) is used once for reads and once for writes.

Test Plan:
1. Read 0x8000_0010; SRAM answers 0xdeadbeef after 2 wait cycles -> s_arvalid=3'b001, m_rdata=0xdeadbeef, m_rresp=00, s_arvalid[2:1] never set.
2. Write 0xa000_03f8 with data 0x41 -> s_awvalid=3'b010, s_wdata=0x41, m_bresp=00, then back to IDLE.
3. Read 0x0000_0000 -> s_arvalid stays 0, m_rvalid=1 two cycles after arvalid, m_rresp=11, m_rdata=0.
4. Same cycle: arvalid for 0x8000_0000 and aw/w for 0xa000_0048 -> read completes first, then the write goes to slave 2; never two transactions outstanding.
5. Slave 1 gives wready immediately and awready 3 cycles later -> s_wvalid drops after 1 cycle, s_awvalid holds for 4 cycles, m_bvalid only after both.
6. rst pulsed in RD_RESP while s_rvalid=1 -> next cycle all valids are 0; m_arready=1 in the first cycle after release.

Source files
------------

// File: rtl/ysyx_23060240_axi_pkg.sv
// ============================================================================
// Module   : ysyx_23060240_axi_pkg
// Brief    : Shared crossbar constants, address map and FSM state encoding.
// Revision : 1.0
// ============================================================================
`default_nettype none

package ysyx_23060240_axi_pkg;

    localparam int NUM_SLV = 3;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    localparam logic [31:0] S0_BASE = 32'h8000_0000;
    localparam logic [31:0] S0_SIZE = 32'h0800_0000;
    localparam logic [31:0] S1_BASE = 32'ha000_03f8;
    localparam logic [31:0] S1_SIZE = 32'h0000_0008;
    localparam logic [31:0] S2_BASE = 32'ha000_0048;
    localparam logic [31:0] S2_SIZE = 32'h0000_0008;

    localparam logic [NUM_SLV-1:0][31:0] SLV_BASE = {S2_BASE, S1_BASE, S0_BASE};
    localparam logic [NUM_SLV-1:0][31:0] SLV_SIZE = {S2_SIZE, S1_SIZE, S0_SIZE};

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RD_REQ  = 3'd1,
        ST_RD_RESP = 3'd2,
        ST_WR_REQ  = 3'd3,
        ST_WR_RESP = 3'd4,
        ST_ERR_R   = 3'd5,
        ST_ERR_W   = 3'd6
    } xbar_state_e;

endpackage

`default_nettype wire

// File: rtl/ysyx_23060240_addr_dec.sv
// ============================================================================
// Module   : ysyx_23060240_addr_dec
// Brief    : Combinational address decoder, one-hot slave hit plus miss flag.
// Revision : 1.0
// ============================================================================
`default_nettype none

module ysyx_23060240_addr_dec
    import ysyx_23060240_axi_pkg::*;
(
    input  logic [31:0]        i_addr,
    output logic [NUM_SLV-1:0] o_hit,
    output logic               o_miss
);

    logic [NUM_SLV-1:0] w_raw;

    // Unsigned offset compare cannot overflow at the top of a region.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_SLV; gi++) begin : g_region
            assign w_raw[gi] = (i_addr - SLV_BASE[gi]) < SLV_SIZE[gi];
        end
    endgenerate

    // Isolate the lowest set bit so the lowest index wins on overlap.
    assign o_hit  = w_raw & (~w_raw + NUM_SLV'(1));
    assign o_miss = ~|w_raw;

endmodule

`default_nettype wire

// File: rtl/ysyx_23060240_xbar.sv
// ============================================================================
// Module   : ysyx_23060240_xbar
// Brief    : Single-master, three-slave AXI-lite crossbar with DECERR return.
// Revision : 1.0
// ============================================================================
`default_nettype none

module ysyx_23060240_xbar
    import ysyx_23060240_axi_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic [31:0]          m_araddr,
    input  logic                 m_arvalid,
    output logic                 m_arready,
    output logic [31:0]          m_rdata,
    output logic [1:0]           m_rresp,
    output logic                 m_rvalid,
    input  logic                 m_rready,
    input  logic [31:0]          m_awaddr,
    input  logic                 m_awvalid,
    output logic                 m_awready,
    input  logic [31:0]          m_wdata,
    input  logic                 m_wvalid,
    output logic                 m_wready,
    output logic [1:0]           m_bresp,
    output logic                 m_bvalid,
    input  logic                 m_bready,
    output logic [31:0]          s_araddr,
    output logic [NUM_SLV-1:0]   s_arvalid,
    input  logic [NUM_SLV-1:0]   s_arready,
    input  logic [32*NUM_SLV-1:0] s_rdata,
    input  logic [NUM_SLV-1:0]   s_rvalid,
    output logic [NUM_SLV-1:0]   s_rready,
    output logic [31:0]          s_awaddr,
    output logic [NUM_SLV-1:0]   s_awvalid,
    input  logic [NUM_SLV-1:0]   s_awready,
    output logic [31:0]          s_wdata,
    output logic [NUM_SLV-1:0]   s_wvalid,
    input  logic [NUM_SLV-1:0]   s_wready,
    input  logic [NUM_SLV-1:0]   s_bvalid,
    output logic [NUM_SLV-1:0]   s_bready
);

    xbar_state_e        r_state_q, w_state_d;
    logic [NUM_SLV-1:0] r_sel_q, w_sel_d;
    logic [31:0]        r_addr_q, w_addr_d;
    logic [31:0]        r_wdata_q, w_wdata_d;
    logic               r_aw_done_q, w_aw_done_d;
    logic               r_w_done_q, w_w_done_d;

    logic [NUM_SLV-1:0] w_rd_hit, w_wr_hit;
    logic               w_rd_miss, w_wr_miss;

    ysyx_23060240_addr_dec u_rd_dec (
        .i_addr (m_araddr),
        .o_hit  (w_rd_hit),
        .o_miss (w_rd_miss)
    );

    ysyx_23060240_addr_dec u_wr_dec (
        .i_addr (m_awaddr),
        .o_hit  (w_wr_hit),
        .o_miss (w_wr_miss)
    );

    // One address register serves both directions: only one transaction is ever open.
    assign s_araddr = r_addr_q;
    assign s_awaddr = r_addr_q;
    assign s_wdata  = r_wdata_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q   <= ST_IDLE;
            r_sel_q     <= '0;
            r_addr_q    <= '0;
            r_wdata_q   <= '0;
            r_aw_done_q <= 1'b0;
            r_w_done_q  <= 1'b0;
        end else begin
            r_state_q   <= w_state_d;
            r_sel_q     <= w_sel_d;
            r_addr_q    <= w_addr_d;
            r_wdata_q   <= w_wdata_d;
            r_aw_done_q <= w_aw_done_d;
            r_w_done_q  <= w_w_done_d;
        end
    end

    always_comb begin
        w_state_d   = r_state_q;
        w_sel_d     = r_sel_q;
        w_addr_d    = r_addr_q;
        w_wdata_d   = r_wdata_q;
        w_aw_done_d = r_aw_done_q;
        w_w_done_d  = r_w_done_q;
        m_arready   = 1'b0;
        m_awready   = 1'b0;
        m_wready    = 1'b0;
        m_rvalid    = 1'b0;
        m_rdata     = '0;
        m_rresp     = RESP_OKAY;
        m_bvalid    = 1'b0;
        m_bresp     = RESP_OKAY;
        s_arvalid   = '0;
        s_rready    = '0;
        s_awvalid   = '0;
        s_wvalid    = '0;
        s_bready    = '0;

        // Gating on rst keeps every handshake output quiet during the reset cycle itself.
        if (!rst) begin
            case (r_state_q)
                ST_IDLE: begin
                    if (m_arvalid) begin
                        m_arready = 1'b1;
                        w_addr_d  = m_araddr;
                        w_sel_d   = w_rd_hit;
                        w_state_d = w_rd_miss ? ST_ERR_R : ST_RD_REQ;
                    end else if (m_awvalid && m_wvalid) begin
                        m_awready = 1'b1;
                        m_wready  = 1'b1;
                        w_addr_d  = m_awaddr;
                        w_wdata_d = m_wdata;
                        w_sel_d   = w_wr_hit;
                        w_state_d = w_wr_miss ? ST_ERR_W : ST_WR_REQ;
                    end
                end
                ST_RD_REQ: begin
                    s_arvalid = r_sel_q;
                    if (|(s_arready & r_sel_q)) begin
                        w_state_d = ST_RD_RESP;
                    end
                end
                ST_RD_RESP: begin
                    m_rvalid = |(s_rvalid & r_sel_q);
                    for (int i = 0; i < NUM_SLV; i++) begin
                        if (r_sel_q[i]) begin
                            m_rdata = s_rdata[32*i +: 32];
                        end
                    end
                    s_rready = r_sel_q & {NUM_SLV{m_rready}};
                    if (m_rvalid && m_rready) begin
                        w_state_d = ST_IDLE;
                    end
                end
                ST_WR_REQ: begin
                    s_awvalid   = r_sel_q & {NUM_SLV{~r_aw_done_q}};
                    s_wvalid    = r_sel_q & {NUM_SLV{~r_w_done_q}};
                    w_aw_done_d = r_aw_done_q | (|(s_awvalid & s_awready));
                    w_w_done_d  = r_w_done_q  | (|(s_wvalid & s_wready));
                    if (w_aw_done_d && w_w_done_d) begin
                        w_aw_done_d = 1'b0;
                        w_w_done_d  = 1'b0;
                        w_state_d   = ST_WR_RESP;
                    end
                end
                ST_WR_RESP: begin
                    m_bvalid = |(s_bvalid & r_sel_q);
                    s_bready = r_sel_q & {NUM_SLV{m_bready}};
                    if (m_bvalid && m_bready) begin
                        w_state_d = ST_IDLE;
                    end
                end
                ST_ERR_R: begin
                    m_rvalid = 1'b1;
                    m_rresp  = RESP_DECERR;
                    if (m_rready) begin
                        w_state_d = ST_IDLE;
                    end
                end
                ST_ERR_W: begin
                    m_bvalid = 1'b1;
                    m_bresp  = RESP_DECERR;
                    if (m_bready) begin
                        w_state_d = ST_IDLE;
                    end
                end
                default: begin
                    w_state_d = ST_IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_ysyx_23060240_xbar.sv
// ============================================================================
// Module   : tb_ysyx_23060240_xbar
// Brief    : Self-checking bench for the crossbar with reactive slave models.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_ysyx_23060240_xbar;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] m_araddr, m_awaddr, m_wdata, m_rdata, s_araddr, s_awaddr, s_wdata;
    logic        m_arvalid, m_arready, m_rvalid, m_rready;
    logic        m_awvalid, m_awready, m_wvalid, m_wready, m_bvalid, m_bready;
    logic [1:0]  m_rresp, m_bresp;
    logic [2:0]  s_arvalid, s_arready, s_rvalid, s_rready;
    logic [2:0]  s_awvalid, s_awready, s_wvalid, s_wready, s_bvalid, s_bready;
    logic [95:0] s_rdata;

    int assert_cnt = 0;
    int fail_cnt   = 0;

    ysyx_23060240_xbar dut (
        .clk(clk), .rst(rst),
        .m_araddr(m_araddr), .m_arvalid(m_arvalid), .m_arready(m_arready),
        .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rvalid(m_rvalid), .m_rready(m_rready),
        .m_awaddr(m_awaddr), .m_awvalid(m_awvalid), .m_awready(m_awready),
        .m_wdata(m_wdata), .m_wvalid(m_wvalid), .m_wready(m_wready),
        .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready),
        .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
        .s_rdata(s_rdata), .s_rvalid(s_rvalid), .s_rready(s_rready),
        .s_awaddr(s_awaddr), .s_awvalid(s_awvalid), .s_awready(s_awready),
        .s_wdata(s_wdata), .s_wvalid(s_wvalid), .s_wready(s_wready),
        .s_bvalid(s_bvalid), .s_bready(s_bready)
    );

    always #5 clk = ~clk;

    // Slave model knobs and observations
    int          ar_wait, r_wait, aw_wait, w_wait, b_wait;
    logic [31:0] rd_val;
    int          ar_cnt, r_cnt, aw_cnt, w_cnt, b_cnt, r_sl, wr_sl, b_sl, p_ar_sl;
    bit          r_pend, b_pend, aw_got, w_got, p_ar, p_r, p_aw, p_w, p_b;
    int          obs_ar_sl[$], obs_aw_sl[$], obs_w_sl[$];
    logic [31:0] obs_ar_addr[$], obs_aw_addr[$], obs_w_data[$];
    logic [2:0]  ar_seen, aw_seen, w_seen;
    int          aw_hi, w_hi, multi_hot;

    function automatic int idx3(input logic [2:0] v);
        return v[0] ? 0 : (v[1] ? 1 : 2);
    endfunction

    // Reference address map: plain range test on widened integers.
    function automatic int ref_slave(input logic [31:0] a);
        longint unsigned base [3];
        longint unsigned size [3];
        base[0] = 64'h8000_0000; size[0] = 64'h0800_0000;
        base[1] = 64'ha000_03f8; size[1] = 64'h8;
        base[2] = 64'ha000_0048; size[2] = 64'h8;
        for (int i = 0; i < 3; i++)
            if (64'(a) >= base[i] && 64'(a) < base[i] + size[i]) return i;
        return -1;
    endfunction

    task automatic clear_obs();
        obs_ar_sl.delete(); obs_aw_sl.delete(); obs_w_sl.delete();
        obs_ar_addr.delete(); obs_aw_addr.delete(); obs_w_data.delete();
        ar_seen = '0; aw_seen = '0; w_seen = '0;
        aw_hi = 0; w_hi = 0; multi_hot = 0;
    endtask

    // Reactive slaves: drive at negedge, predict the coming posedge handshakes 1 ns later.
    initial begin
        s_arready = '0; s_rvalid = '0; s_rdata = '0;
        s_awready = '0; s_wready = '0; s_bvalid = '0;
        {r_pend, b_pend, aw_got, w_got, p_ar, p_r, p_aw, p_w, p_b} = '0;
        {ar_cnt, r_cnt, aw_cnt, w_cnt, b_cnt, r_sl, wr_sl, b_sl, p_ar_sl} = '0;
        forever begin
            @(negedge clk);
            if (p_ar) begin r_pend = 1; r_sl = p_ar_sl; r_cnt = 0; ar_cnt = 0; end
            if (p_r) r_pend = 0;
            if (p_aw) begin aw_got = 1; aw_cnt = 0; end
            if (p_w) begin w_got = 1; w_cnt = 0; end
            if (aw_got && w_got) begin aw_got = 0; w_got = 0; b_pend = 1; b_sl = wr_sl; b_cnt = 0; end
            if (p_b) b_pend = 0;
            s_arready = '0;
            if (s_arvalid != 0) begin if (ar_cnt >= ar_wait) s_arready = s_arvalid; else ar_cnt++; end
            s_awready = '0;
            if (s_awvalid != 0) begin if (aw_cnt >= aw_wait) s_awready = s_awvalid; else aw_cnt++; end
            s_wready = '0;
            if (s_wvalid != 0) begin if (w_cnt >= w_wait) s_wready = s_wvalid; else w_cnt++; end
            s_rvalid = '0; s_rdata = '0;
            if (r_pend) begin
                if (r_cnt >= r_wait) begin s_rvalid[r_sl] = 1'b1; s_rdata[r_sl*32 +: 32] = rd_val; end
                else r_cnt++;
            end
            s_bvalid = '0;
            if (b_pend) begin if (b_cnt >= b_wait) s_bvalid[b_sl] = 1'b1; else b_cnt++; end
            #1;
            if (rst) begin
                s_arready = '0; s_rvalid = '0; s_rdata = '0;
                s_awready = '0; s_wready = '0; s_bvalid = '0;
                {r_pend, b_pend, aw_got, w_got, p_ar, p_r, p_aw, p_w, p_b} = '0;
                {ar_cnt, r_cnt, aw_cnt, w_cnt, b_cnt} = '0;
            end else begin
                ar_seen |= s_arvalid; aw_seen |= s_awvalid; w_seen |= s_wvalid;
                if (s_awvalid != 0) aw_hi++;
                if (s_wvalid != 0) w_hi++;
                if ($countones(s_arvalid) > 1 || $countones(s_awvalid) > 1 || $countones(s_wvalid) > 1 ||
                    $countones(s_rready) > 1 || $countones(s_bready) > 1) multi_hot++;
                p_ar = |(s_arvalid & s_arready);
                p_r  = |(s_rvalid & s_rready);
                p_aw = |(s_awvalid & s_awready);
                p_w  = |(s_wvalid & s_wready);
                p_b  = |(s_bvalid & s_bready);
                if (p_ar) begin p_ar_sl = idx3(s_arvalid); obs_ar_sl.push_back(p_ar_sl); obs_ar_addr.push_back(s_araddr); end
                if (p_aw) begin wr_sl = idx3(s_awvalid); obs_aw_sl.push_back(wr_sl); obs_aw_addr.push_back(s_awaddr); end
                if (p_w) begin obs_w_sl.push_back(idx3(s_wvalid)); obs_w_data.push_back(s_wdata); end
            end
        end
    end

    task automatic do_read(input logic [31:0] a, output logic [31:0] data, output logic [1:0] resp,
                           output int lat, output bit acc);
        @(negedge clk); m_arvalid = 1; m_araddr = a; m_rready = 1;
        #2; acc = m_arready;
        @(negedge clk); m_arvalid = 0; lat = 1; data = '0; resp = 2'b01;
        while (lat < 60) begin
            #2;
            if (m_rvalid) begin data = m_rdata; resp = m_rresp; break; end
            @(negedge clk); lat++;
        end
        @(negedge clk); m_rready = 0;
    endtask

    task automatic do_write(input logic [31:0] a, input logic [31:0] d, output logic [1:0] resp,
                            output int lat, output bit acc);
        @(negedge clk); m_awvalid = 1; m_wvalid = 1; m_awaddr = a; m_wdata = d; m_bready = 1;
        #2; acc = m_awready && m_wready;
        @(negedge clk); m_awvalid = 0; m_wvalid = 0; lat = 1; resp = 2'b01;
        while (lat < 60) begin
            #2;
            if (m_bvalid) begin resp = m_bresp; break; end
            @(negedge clk); lat++;
        end
        @(negedge clk); m_bready = 0;
    endtask

    task automatic test_reset();
        @(negedge clk); rst = 1; m_arvalid = 1; m_awvalid = 1; m_wvalid = 1;
        @(negedge clk); #2;
        assert_cnt++;
        if ({m_arready, m_awready, m_wready} !== 3'b000) begin
            fail_cnt++; $display("FAIL reset_mready: got %b want 000", {m_arready, m_awready, m_wready});
        end
        assert_cnt++;
        if ({s_arvalid, s_awvalid, s_wvalid, s_rready, s_bready, m_rvalid, m_bvalid} !== 17'd0) begin
            fail_cnt++; $display("FAIL reset_valids: got %h want 0",
                                 {s_arvalid, s_awvalid, s_wvalid, s_rready, s_bready, m_rvalid, m_bvalid});
        end
        @(negedge clk); rst = 0; m_arvalid = 0; m_awvalid = 0; m_wvalid = 0;
        #2;
        assert_cnt++;
        if ({s_araddr, s_wdata} !== 64'd0) begin
            fail_cnt++; $display("FAIL reset_latched: got %h want 0", {s_araddr, s_wdata});
        end
    endtask

    task automatic test_read_sram();
        logic [31:0] d; logic [1:0] r; int lat; bit acc;
        ar_wait = 0; r_wait = 2; rd_val = 32'hdead_beef; clear_obs();
        do_read(32'h8000_0010, d, r, lat, acc);
        assert_cnt++;
        if (!acc || d !== 32'hdead_beef || r !== 2'b00) begin
            fail_cnt++; $display("FAIL sram_read: acc %0d data %h resp %b want 1 deadbeef 00", acc, d, r);
        end
        assert_cnt++;
        if (lat != 4) begin fail_cnt++; $display("FAIL sram_read_lat: got %0d want 4", lat); end
        assert_cnt++;
        if (ar_seen !== 3'b001 || obs_ar_addr.size() != 1 || obs_ar_addr[0] !== 32'h8000_0010) begin
            fail_cnt++; $display("FAIL sram_route: seen %b n %0d want 001 n 1", ar_seen, obs_ar_addr.size());
        end
    endtask

    task automatic test_write_uart();
        logic [1:0] r; int lat; bit acc;
        aw_wait = 0; w_wait = 0; b_wait = 0; clear_obs();
        do_write(32'ha000_03f8, 32'h41, r, lat, acc);
        assert_cnt++;
        if (!acc || r !== 2'b00 || lat != 2) begin
            fail_cnt++; $display("FAIL uart_write: acc %0d resp %b lat %0d want 1 00 2", acc, r, lat);
        end
        assert_cnt++;
        if (aw_seen !== 3'b010 || w_seen !== 3'b010 || obs_w_data.size() != 1 || obs_w_data[0] !== 32'h41) begin
            fail_cnt++; $display("FAIL uart_route: aw %b w %b ndata %0d want 010 010 1", aw_seen, w_seen, obs_w_data.size());
        end
        #2;
        assert_cnt++;
        if (m_bvalid !== 1'b0) begin fail_cnt++; $display("FAIL uart_idle: bvalid %b want 0", m_bvalid); end
    endtask

    task automatic test_decerr();
        logic [31:0] d; logic [1:0] r; int lat; bit acc;
        rd_val = 32'h1234_5678; clear_obs();
        do_read(32'h0000_0000, d, r, lat, acc);
        assert_cnt++;
        if (!acc || d !== 32'd0 || r !== 2'b11 || lat != 1 || ar_seen !== 3'b000) begin
            fail_cnt++; $display("FAIL decerr_read: acc %0d data %h resp %b lat %0d seen %b want 1 0 11 1 000",
                                 acc, d, r, lat, ar_seen);
        end
        clear_obs();
        do_write(32'h9000_0000, 32'hffff_0000, r, lat, acc);
        assert_cnt++;
        if (!acc || r !== 2'b11 || lat != 1 || (aw_seen | w_seen) !== 3'b000) begin
            fail_cnt++; $display("FAIL decerr_write: acc %0d resp %b lat %0d seen %b want 1 11 1 000",
                                 acc, r, lat, aw_seen | w_seen);
        end
    endtask

    task automatic test_priority();
        int n; int early_w = 0;
        ar_wait = 1; r_wait = 1; aw_wait = 0; w_wait = 0; b_wait = 0; rd_val = 32'hcafe_f00d; clear_obs();
        @(negedge clk);
        m_arvalid = 1; m_araddr = 32'h8000_0000; m_rready = 1;
        m_awvalid = 1; m_wvalid = 1; m_awaddr = 32'ha000_0048; m_wdata = 32'h1234; m_bready = 1;
        #2;
        assert_cnt++;
        if ({m_arready, m_awready, m_wready} !== 3'b100) begin
            fail_cnt++; $display("FAIL prio_accept: got %b want 100", {m_arready, m_awready, m_wready});
        end
        @(negedge clk); m_arvalid = 0; n = 0;
        while (n < 40) begin
            #2;
            if (m_awready || m_wready) early_w++;
            if (m_rvalid) break;
            @(negedge clk); n++;
        end
        assert_cnt++;
        if (!m_rvalid || m_rdata !== 32'hcafe_f00d || early_w != 0) begin
            fail_cnt++; $display("FAIL prio_read: rvalid %b data %h early_w %0d want 1 cafef00d 0", m_rvalid, m_rdata, early_w);
        end
        @(negedge clk); m_rready = 0; #2;
        assert_cnt++;
        if (!(m_awready && m_wready)) begin
            fail_cnt++; $display("FAIL prio_write_accept: got %b%b want 11", m_awready, m_wready);
        end
        @(negedge clk); m_awvalid = 0; m_wvalid = 0; n = 0;
        while (n < 40) begin #2; if (m_bvalid) break; @(negedge clk); n++; end
        assert_cnt++;
        if (!m_bvalid || m_bresp !== 2'b00 || obs_ar_sl.size() != 1 || obs_ar_sl[0] != 0 ||
            obs_aw_sl.size() != 1 || obs_aw_sl[0] != 2 || obs_w_data.size() != 1 || obs_w_data[0] !== 32'h1234) begin
            fail_cnt++; $display("FAIL prio_order: bvalid %b bresp %b nar %0d naw %0d want 1 00 1 1",
                                 m_bvalid, m_bresp, obs_ar_sl.size(), obs_aw_sl.size());
        end
        @(negedge clk); m_bready = 0;
    endtask

    task automatic test_wr_split();
        logic [1:0] r; int lat; bit acc;
        aw_wait = 3; w_wait = 0; b_wait = 0; clear_obs();
        do_write(32'ha000_03fc, 32'h55, r, lat, acc);
        assert_cnt++;
        if (w_hi != 1 || aw_hi != 4 || lat != 5 || r !== 2'b00) begin
            fail_cnt++; $display("FAIL split_aw_late: w_hi %0d aw_hi %0d lat %0d resp %b want 1 4 5 00", w_hi, aw_hi, lat, r);
        end
        aw_wait = 0; w_wait = 2; clear_obs();
        do_write(32'h8000_0100, 32'h66, r, lat, acc);
        assert_cnt++;
        if (w_hi != 3 || aw_hi != 1 || lat != 4 || w_seen !== 3'b001) begin
            fail_cnt++; $display("FAIL split_w_late: w_hi %0d aw_hi %0d lat %0d seen %b want 3 1 4 001", w_hi, aw_hi, lat, w_seen);
        end
    endtask

    task automatic test_reset_mid();
        int n;
        ar_wait = 0; r_wait = 0; rd_val = 32'hbeef_0001;
        @(negedge clk); m_arvalid = 1; m_araddr = 32'h8000_0100; m_rready = 0;
        @(negedge clk); m_arvalid = 0; n = 0;
        while (n < 20) begin #2; if (m_rvalid) break; @(negedge clk); n++; end
        assert_cnt++;
        if (m_rvalid !== 1'b1) begin fail_cnt++; $display("FAIL rstmid_pre: rvalid %b want 1", m_rvalid); end
        @(negedge clk); rst = 1;
        @(negedge clk); rst = 0; m_arvalid = 1; m_araddr = 32'h0; #2;
        assert_cnt++;
        if ({m_rvalid, m_bvalid, s_arvalid, s_awvalid, s_wvalid, s_rready, s_bready} !== 17'd0 || m_arready !== 1'b1) begin
            fail_cnt++; $display("FAIL rstmid_after: valids %h arready %b want 0 1",
                                 {m_rvalid, m_bvalid, s_arvalid, s_awvalid, s_wvalid, s_rready, s_bready}, m_arready);
        end
        @(negedge clk); m_arvalid = 0; m_rready = 1; n = 0;
        while (n < 20) begin #2; if (m_rvalid) break; @(negedge clk); n++; end
        assert_cnt++;
        if (m_rvalid !== 1'b1 || m_rresp !== 2'b11) begin
            fail_cnt++; $display("FAIL rstmid_resume: rvalid %b resp %b want 1 11", m_rvalid, m_rresp);
        end
        @(negedge clk); m_rready = 0;
    endtask

    task automatic test_random();
        logic [31:0] a, d, got; logic [1:0] r; int lat, sl, elat; bit acc, is_rd;
        logic [31:0] edges [8];
        edges = '{32'h87ff_fffc, 32'h8800_0000, 32'ha000_03ff, 32'ha000_0400,
                  32'ha000_0047, 32'ha000_004f, 32'hffff_ffff, 32'h7fff_ffff};
        for (int t = 0; t < 40; t++) begin
            case ($urandom_range(0, 4))
                0: a = 32'h8000_0000 + ($urandom & 32'h07ff_ffff);
                1: a = 32'ha000_03f8 + 32'($urandom_range(0, 7));
                2: a = 32'ha000_0048 + 32'($urandom_range(0, 7));
                3: a = $urandom;
                default: a = edges[$urandom_range(0, 7)];
            endcase
            ar_wait = $urandom_range(0, 3); r_wait = $urandom_range(0, 3);
            aw_wait = $urandom_range(0, 3); w_wait = $urandom_range(0, 3); b_wait = $urandom_range(0, 3);
            rd_val = $urandom; d = $urandom; is_rd = $urandom_range(0, 1) == 1;
            sl = ref_slave(a); clear_obs();
            if (is_rd) begin
                do_read(a, got, r, lat, acc);
                elat = (sl < 0) ? 1 : 2 + ar_wait + r_wait;
                assert_cnt++;
                if (!acc || r !== ((sl < 0) ? 2'b11 : 2'b00) || got !== ((sl < 0) ? 32'd0 : rd_val) || lat != elat ||
                    ar_seen !== ((sl < 0) ? 3'b000 : 3'(1 << sl)) ||
                    (sl >= 0 && (obs_ar_addr.size() != 1 || obs_ar_addr[0] !== a)) || multi_hot != 0) begin
                    fail_cnt++; $display("FAIL rand_read a=%h: data %h resp %b lat %0d seen %b want slave %0d data %h lat %0d",
                                         a, got, r, lat, ar_seen, sl, rd_val, elat);
                end
            end else begin
                do_write(a, d, r, lat, acc);
                elat = (sl < 0) ? 1 : 2 + ((aw_wait > w_wait) ? aw_wait : w_wait) + b_wait;
                assert_cnt++;
                if (!acc || r !== ((sl < 0) ? 2'b11 : 2'b00) || lat != elat ||
                    aw_seen !== ((sl < 0) ? 3'b000 : 3'(1 << sl)) || w_seen !== aw_seen ||
                    (sl >= 0 && (obs_w_data.size() != 1 || obs_w_data[0] !== d ||
                                 obs_aw_addr.size() != 1 || obs_aw_addr[0] !== a)) || multi_hot != 0) begin
                    fail_cnt++; $display("FAIL rand_write a=%h: resp %b lat %0d aw %b w %b want slave %0d lat %0d",
                                         a, r, lat, aw_seen, w_seen, sl, elat);
                end
            end
        end
    endtask

    initial begin
        rst = 1;
        m_araddr = '0; m_arvalid = 0; m_rready = 0;
        m_awaddr = '0; m_awvalid = 0; m_wdata = '0; m_wvalid = 0; m_bready = 0;
        ar_wait = 0; r_wait = 0; aw_wait = 0; w_wait = 0; b_wait = 0; rd_val = '0;
        clear_obs();
        repeat (2) @(negedge clk);
        test_reset();
        test_read_sram();
        test_write_uart();
        test_decerr();
        test_priority();
        test_wr_split();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, %0d failures so far", fail_cnt);
        $fatal(1);
    end

endmodule

`default_nettype wire
